// File: rtl/flash_sample_reader.sv
// Streams audio samples from a word-wide Avalon-MM flash, keeping one word
// buffered so neighbouring samples in the same word need no further bus read.
module flash_sample_reader #(
    parameter int  ADDR_W   = 23,
    parameter int  WORD_W   = 32,
    parameter int  SAMPLE_W = 16,
    localparam int SPW      = WORD_W / SAMPLE_W,
    localparam int LSPW     = $clog2(SPW),
    localparam int WADDR_W  = ADDR_W - LSPW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                play_en,
    input  logic                restart,
    input  logic                dir,
    input  logic                loop,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    output logic [WADDR_W-1:0]  address,
    output logic                read,
    input  logic                waitrequest,
    input  logic [WORD_W-1:0]   readdata,
    input  logic                readdatavalid,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                done,
    output logic                range_err,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_DATA, PRESENT, ADVANCE, HOLD, DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt, adv_idx, reload_idx, shift_amt;
    logic                adv_end;
    logic                pending, pending_nxt;
    logic                range_err_nxt;
    logic                buf_valid, buf_load;
    logic [WADDR_W-1:0]  buf_word;
    logic [WORD_W-1:0]   buf_data;

    function automatic logic [WADDR_W-1:0] word_of(input logic [ADDR_W-1:0] i);
        return WADDR_W'(i >> LSPW);
    endfunction

    // Where to go once a new idx is known: pause, reuse the buffered word, or fetch.
    function automatic state_t follow_on(input logic run, input logic hit);
        if (!run)
            return HOLD;
        else if (hit)
            return PRESENT;
        else
            return REQ;
    endfunction

    // Sample stream handshake: a sample transfers on a rising edge where
    // sample_valid and sample_ready are both 1; while sample_valid=1 and
    // sample_ready=0, sample_data holds. A restart wins over a same-cycle accept.
    assign read         = (state == REQ);
    assign address      = word_of(idx);
    assign sample_valid = (state == PRESENT);
    assign shift_amt    = (idx & ADDR_W'(SPW - 1)) * ADDR_W'(SAMPLE_W);
    assign sample_data  = (state == PRESENT) ? SAMPLE_W'(buf_data >> shift_amt) : '0;
    assign done         = (state == DONE) ||
                          (state == ADVANCE && adv_end && !loop && !restart);
    assign state_dbg    = state;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        pending_nxt   = pending;
        range_err_nxt = range_err;
        buf_load      = 1'b0;
        reload_idx    = dir ? start_addr : end_addr;
        adv_end       = 1'b0;
        adv_idx       = idx;
        if (dir) begin
            if (idx == end_addr) begin
                adv_end = 1'b1;
                adv_idx = start_addr;
            end else begin
                adv_idx = idx + 1'b1;
            end
        end else begin
            if (idx == start_addr) begin
                adv_end = 1'b1;
                adv_idx = end_addr;
            end else begin
                adv_idx = idx - 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (play_en) begin
                    if (start_addr <= end_addr) begin
                        idx_nxt       = reload_idx;
                        range_err_nxt = 1'b0;
                        state_nxt     = REQ;
                    end else begin
                        range_err_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                if (restart)
                    pending_nxt = 1'b1;
                if (!waitrequest)
                    state_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (restart)
                    pending_nxt = 1'b1;
                if (readdatavalid) begin
                    buf_load = 1'b1;
                    // A restart seen during the read: keep the word, never show it.
                    if (pending || restart) begin
                        pending_nxt = 1'b0;
                        idx_nxt     = reload_idx;
                        state_nxt   = follow_on(play_en, word_of(reload_idx) == word_of(idx));
                    end else begin
                        state_nxt = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (restart) begin
                    idx_nxt   = reload_idx;
                    state_nxt = HOLD;
                end else if (sample_ready) begin
                    state_nxt = ADVANCE;
                end
            end
            ADVANCE: begin
                if (restart) begin
                    idx_nxt   = reload_idx;
                    state_nxt = HOLD;
                end else if (adv_end && !loop) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = adv_idx;
                    state_nxt = follow_on(play_en,
                                          buf_valid && word_of(adv_idx) == buf_word);
                end
            end
            HOLD: begin
                if (restart)
                    idx_nxt = reload_idx;
                else if (play_en)
                    state_nxt = follow_on(1'b1, buf_valid && word_of(idx) == buf_word);
            end
            DONE: begin
                if (restart || !play_en)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            pending   <= 1'b0;
            range_err <= 1'b0;
            buf_valid <= 1'b0;
            buf_word  <= '0;
            buf_data  <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            pending   <= pending_nxt;
            range_err <= range_err_nxt;
            if (buf_load) begin
                buf_data  <= readdata;
                buf_word  <= word_of(idx);
                buf_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader: Avalon flash responder, sample
// scoreboard fed by the stimulus steps, and immediate-assertion checks.
module tb_flash_sample_reader;

    localparam int ADDR_W   = 23;
    localparam int WORD_W   = 32;
    localparam int SAMPLE_W = 16;
    localparam int WADDR_W  = 22;

    logic                clk = 1'b0;
    logic                rst, play_en, restart, dir, loop;
    logic [ADDR_W-1:0]   start_addr, end_addr;
    logic [WADDR_W-1:0]  address;
    logic                read, waitrequest, readdatavalid;
    logic [WORD_W-1:0]   readdata;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid, sample_ready, done, range_err;
    logic [2:0]          state_dbg;

    int n_checks = 0;
    int n_fails  = 0;
    int read_count = 0;
    int accept_cnt = 0;
    int stall_n = 0;
    int lat_n   = 1;
    bit first_seen = 0;
    bit in_data_wait = 0;
    bit rdy_rand = 0;
    logic rdy_fixed = 1'b1;
    logic [WADDR_W-1:0] first_addr;
    logic [WORD_W-1:0]  mem [0:7];
    logic [SAMPLE_W-1:0] exp_q[$];

    flash_sample_reader dut (
        .clk(clk), .rst(rst), .play_en(play_en), .restart(restart), .dir(dir),
        .loop(loop), .start_addr(start_addr), .end_addr(end_addr),
        .address(address), .read(read), .waitrequest(waitrequest),
        .readdata(readdata), .readdatavalid(readdatavalid),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .done(done), .range_err(range_err),
        .state_dbg(state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Avalon flash responder: optional stall, then data after lat_n cycles.
    initial begin : avalon_slave
        logic [WADDR_W-1:0] addr;
        bit aborted;
        waitrequest   = 1'b0;
        readdatavalid = 1'b0;
        readdata      = '0;
        forever begin
            @(negedge clk);
            readdatavalid = 1'b0;
            if (read === 1'b1 && !rst) begin
                read_count++;
                addr = address;
                if (!first_seen) begin
                    first_seen = 1;
                    first_addr = addr;
                end
                aborted = 0;
                if (stall_n > 0) begin
                    waitrequest = 1'b1;
                    for (int k = 0; k < stall_n; k++) begin
                        @(negedge clk);
                        if (rst) begin
                            aborted = 1;
                            break;
                        end
                        chk("stall_read", 32'(read), 32'(1));
                        chk("stall_addr", 32'(address), 32'(addr));
                    end
                    waitrequest = 1'b0;
                end
                if (aborted) begin
                    while (rst) @(negedge clk);
                    readdata      = mem[addr[2:0]];
                    readdatavalid = 1'b1;
                end else begin
                    in_data_wait = 1;
                    for (int k = 0; k < lat_n; k++) begin
                        @(negedge clk);
                        chk("no_second_read", 32'(read), 32'(0));
                    end
                    in_data_wait  = 0;
                    readdata      = mem[addr[2:0]];
                    readdatavalid = 1'b1;
                end
            end
        end
    end

    initial begin : ready_driver
        sample_ready = 1'b0;
        forever begin
            @(negedge clk);
            sample_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        end
    end

    // Scoreboard: every accepted sample is popped against exp_q.
    initial begin : sample_monitor
        logic [SAMPLE_W-1:0] exp_s, prev_data;
        bit prev_pend;
        prev_pend = 0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_pend = 0;
            end else begin
                if (prev_pend && sample_valid === 1'b1)
                    chk("sample_stable", 32'(sample_data), 32'(prev_data));
                if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
                    accept_cnt++;
                    n_checks++;
                    assert (exp_q.size() != 0) else begin
                        n_fails++;
                        $error("FAIL unexpected_sample: observed %0h expected none", sample_data);
                    end
                    if (exp_q.size() != 0) begin
                        exp_s = exp_q.pop_front();
                        chk("sample_data", 32'(sample_data), 32'(exp_s));
                    end
                    prev_pend = 0;
                end else begin
                    prev_pend = (sample_valid === 1'b1);
                    prev_data = sample_data;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_accepts(input int target, input int budget, input string tag);
        int c = 0;
        while (accept_cnt < target && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        chk(tag, 32'(accept_cnt), 32'(target));
    endtask

    task automatic do_reset();
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        @(negedge clk);
        play_en = 1'b0;
        restart = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #2;
        accept_cnt = 0;
        read_count = 0;
        first_seen = 0;
        exp_q.delete();
    endtask

    task automatic launch(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                          input logic d, input logic l);
        start_addr = s;
        end_addr   = e;
        dir        = d;
        loop       = l;
        play_en    = 1'b1;
    endtask

    initial begin : main
        int c;
        rst = 1'b1; play_en = 1'b0; restart = 1'b0; dir = 1'b1; loop = 1'b1;
        start_addr = '0; end_addr = 23'd3;
        mem[0] = 32'hBBBB_AAAA; mem[1] = 32'hDDDD_CCCC;
        mem[2] = 32'h2222_1111; mem[3] = 32'h4444_3333;
        mem[4] = 32'h6666_5555; mem[5] = 32'h8888_7777;
        mem[6] = 32'hAAAA_9999; mem[7] = 32'hCCCC_BBBB;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_read", 32'(read), 32'(0));
        chk("rst_address", 32'(address), 32'(0));
        chk("rst_sample_valid", 32'(sample_valid), 32'(0));
        chk("rst_sample_data", 32'(sample_data), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_range_err", 32'(range_err), 32'(0));
        chk("rst_state", 32'(state_dbg), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Forward loop with random backpressure, then pause and resume from cache
        rdy_rand = 1;
        exp_q.push_back(16'hAAAA); exp_q.push_back(16'hBBBB); exp_q.push_back(16'hCCCC);
        exp_q.push_back(16'hDDDD); exp_q.push_back(16'hAAAA);
        launch(23'd0, 23'd3, 1'b1, 1'b1);
        wait_accepts(5, 300, "fwd_accepts");
        play_en = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        chk("fwd_read_count", 32'(read_count), 32'(3));
        chk("paused_state_hold", 32'(state_dbg), 32'(5));
        chk("paused_no_valid", 32'(sample_valid), 32'(0));
        exp_q.push_back(16'hBBBB);
        play_en = 1'b1;
        wait_accepts(6, 100, "resume_accepts");
        play_en = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("resume_no_read", 32'(read_count), 32'(3));
        do_reset();

        // Backward loop
        exp_q.push_back(16'hDDDD); exp_q.push_back(16'hCCCC); exp_q.push_back(16'hBBBB);
        exp_q.push_back(16'hAAAA); exp_q.push_back(16'hDDDD);
        launch(23'd0, 23'd3, 1'b0, 1'b1);
        wait_accepts(5, 300, "bwd_accepts");
        play_en = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        chk("bwd_first_addr", 32'(first_addr), 32'(1));
        chk("bwd_read_count", 32'(read_count), 32'(3));
        do_reset();

        // Forward, no loop: done exactly one cycle after the last accept
        rdy_rand = 0;
        exp_q.push_back(16'hAAAA); exp_q.push_back(16'hBBBB);
        exp_q.push_back(16'hCCCC); exp_q.push_back(16'hDDDD);
        launch(23'd0, 23'd3, 1'b1, 1'b0);
        wait_accepts(4, 200, "noloop_accepts");
        @(posedge clk);
        #1;
        chk("done_after_last", 32'(done), 32'(1));
        chk("done_no_valid", 32'(sample_valid), 32'(0));
        repeat (10) @(negedge clk);
        #2;
        chk("done_held", 32'(done), 32'(1));
        chk("done_read_low", 32'(read), 32'(0));
        chk("done_read_count", 32'(read_count), 32'(2));
        play_en = 1'b0;
        @(posedge clk);
        #1;
        chk("done_cleared", 32'(done), 32'(0));
        chk("done_to_idle", 32'(state_dbg), 32'(0));
        do_reset();

        // Long stall and slow data on a single-sample range
        stall_n = 5;
        lat_n   = 3;
        exp_q.push_back(16'hCCCC);
        launch(23'd2, 23'd2, 1'b1, 1'b0);
        wait_accepts(1, 100, "stall_accepts");
        c = 0;
        while (done !== 1'b1 && c < 20) begin
            @(negedge clk);
            #2;
            c++;
        end
        chk("stall_done", 32'(done), 32'(1));
        chk("stall_read_count", 32'(read_count), 32'(1));
        stall_n = 0;
        do_reset();

        // Restart while word 1 is in flight: word consumed, stream restarts at AAAA
        lat_n = 4;
        exp_q.push_back(16'hAAAA); exp_q.push_back(16'hBBBB); exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'hBBBB); exp_q.push_back(16'hCCCC);
        launch(23'd0, 23'd3, 1'b1, 1'b1);
        wait_accepts(2, 100, "rs_pre_accepts");
        c = 0;
        while (!in_data_wait && c < 30) begin
            @(negedge clk);
            #2;
            c++;
        end
        chk("rs_read_in_flight", 32'(in_data_wait), 32'(1));
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_accepts(5, 200, "rs_accepts");
        play_en = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        chk("rs_read_count", 32'(read_count), 32'(4));
        lat_n = 1;
        do_reset();

        // Reset in the middle of a stalled request, then a late response
        stall_n = 8;
        launch(23'd4, 23'd7, 1'b1, 1'b1);
        c = 0;
        while (read !== 1'b1 && c < 20) begin
            @(negedge clk);
            #2;
            c++;
        end
        chk("mid_req_read_seen", 32'(read), 32'(1));
        chk("mid_req_address", 32'(address), 32'(2));
        play_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_read", 32'(read), 32'(0));
        chk("async_rst_address", 32'(address), 32'(0));
        chk("async_rst_state", 32'(state_dbg), 32'(0));
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        stall_n = 0;
        repeat (5) @(negedge clk);
        #2;
        chk("late_rdv_state", 32'(state_dbg), 32'(0));
        chk("late_rdv_no_valid", 32'(sample_valid), 32'(0));
        chk("late_rdv_no_accept", 32'(accept_cnt), 32'(0));
        read_count = 0;

        // Inverted range rejected, then cleared by a valid launch
        launch(23'd5, 23'd2, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        #2;
        chk("range_err_set", 32'(range_err), 32'(1));
        chk("range_err_idle", 32'(state_dbg), 32'(0));
        chk("range_err_no_read", 32'(read_count), 32'(0));
        start_addr = 23'd2;
        end_addr   = 23'd5;
        @(posedge clk);
        #1;
        chk("range_err_cleared", 32'(range_err), 32'(0));
        chk("range_ok_read", 32'(read), 32'(1));
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
